// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - Clause-22 MDIO codes, frame layout and controller state encoding
package mdio_pkg;

  localparam int FRAME_BITS = 32;
  localparam int RD_OE_BITS = 14;
  localparam int DATA_BITS  = 16;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  localparam int ST_MSB    = 31;
  localparam int OP_MSB    = 29;
  localparam int PHYAD_MSB = 27;
  localparam int REGAD_MSB = 22;
  localparam int TA_MSB    = 17;
  localparam int DATA_MSB  = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SEND,
    S_RECV,
    S_DONE
  } mdio_state_t;

  function automatic logic is_read_op(input logic [1:0] op);
    return op == OP_RD;
  endfunction

endpackage

// File: rtl/mdio_master_ctrl_if.sv
// rtl/mdio_master_ctrl_if.sv - frame request and MDIO pin bundle of the management master
interface mdio_master_ctrl_if;
  logic        start;
  logic [31:0] t_data;
  logic        mdio_in;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        busy;

  modport master (
    input  start, t_data, mdio_in,
    output mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy
  );

  modport slave (
    output start, t_data, mdio_in,
    input  mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy
  );
endinterface

// File: rtl/mdio_mdc_div.sv
// rtl/mdio_mdc_div.sv - MDC generator with one-cycle rise/fall enables
module mdio_mdc_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic mdc,
  output logic rise_en,
  output logic fall_en
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] cnt;

  // Enables flag the cycle before the edge, so users act on the same clock that moves MDC.
  assign rise_en = en && !clr && (cnt == CNT_RISE);
  assign fall_en = en && !clr && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (clr || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_RISE) mdc <= 1'b1;
    end
  end
endmodule

// File: rtl/mdio_master_ctrl.sv
// rtl/mdio_master_ctrl.sv - MDIO Clause-22 master: serialises frames, captures read data
// MDIO_PREAMBLE_EN: prefix each frame with 32 MDC periods of driven ones.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic                clk,
  input logic                rst,
  mdio_master_ctrl_if.master bus
);
`ifdef MDIO_PREAMBLE_EN
  localparam mdio_state_t FIRST_STATE = S_PREAMBLE;
`else
  localparam mdio_state_t FIRST_STATE = S_SEND;
`endif

  mdio_state_t state, state_nxt;
  logic [31:0] sreg;
  logic [15:0] sin;
  logic [15:0] rd_data_q;
  logic [5:0]  bit_cnt;
  logic        rd_frame;
  logic        mdc, rise_en, fall_en;
  logic        frame_start, running, last_bit;

  assign frame_start = (state == S_IDLE) && bus.start;
  assign running     = (state == S_PREAMBLE) || (state == S_SEND) || (state == S_RECV);
  assign last_bit    = bit_cnt == 6'(FRAME_BITS - 1);

  mdio_mdc_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .clr     (frame_start),
    .en      (running),
    .mdc     (mdc),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.start) state_nxt = FIRST_STATE;
      S_PREAMBLE: if (fall_en && last_bit) state_nxt = S_SEND;
      S_SEND: begin
        if (fall_en) begin
          if (rd_frame && bit_cnt == 6'(RD_OE_BITS - 1)) state_nxt = S_RECV;
          else if (last_bit)                             state_nxt = S_DONE;
        end
      end
      S_RECV:     if (fall_en && last_bit) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      sin       <= '0;
      rd_data_q <= '0;
      bit_cnt   <= '0;
      rd_frame  <= 1'b0;
    end else if (frame_start) begin
      sreg     <= bus.t_data;
      sin      <= '0;
      bit_cnt  <= '0;
      rd_frame <= is_read_op(bus.t_data[OP_MSB -: 2]);
    end else begin
      if (fall_en) begin
        if (state == S_SEND) sreg <= {sreg[30:0], 1'b0};
        // Preamble rolls the counter over into the frame; a frame's last bit parks it.
        if (!last_bit)                 bit_cnt <= bit_cnt + 6'd1;
        else if (state == S_PREAMBLE)  bit_cnt <= '0;
      end
      // Turnaround periods are skipped; only the 16 data periods shift in.
      if (rise_en && state == S_RECV && bit_cnt >= 6'(FRAME_BITS - DATA_BITS))
        sin <= {sin[14:0], bus.mdio_in};
      if (fall_en && state == S_RECV && last_bit)
        rd_data_q <= sin;
    end
  end

  assign bus.mdc      = mdc;
  assign bus.mdio_oe  = (state == S_PREAMBLE) || (state == S_SEND);
  assign bus.mdio_out = (state == S_PREAMBLE) || ((state == S_SEND) && sreg[31]);
  assign bus.rd_data  = rd_data_q;
  assign bus.data_rdy = (state == S_DONE) && rd_frame;
  assign bus.busy     = state != S_IDLE;
endmodule

// File: tb/tb_mdio_master_ctrl.sv
// tb/tb_mdio_master_ctrl.sv - table-driven and random frame checks against a PHY-side model
module tb_mdio_master_ctrl;
  parameter int CLK_DIV = 4;
`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif
  localparam int NB  = PRE + 32;
  localparam int LAT = NB * CLK_DIV + 1;

  typedef struct {
    logic [31:0] td;
    logic [15:0] phy;
    logic [15:0] exp_rd;
    int          exp_rdy;
    int          mode;
    logic [31:0] td2;
    logic [15:0] exp_rd2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  mdio_master_ctrl_if ifc ();

  mdio_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          rise_cnt = 0;
  int          last_rises = 0;
  int          rdy_cnt = 0;
  logic        mdc_q = 1'b0;
  logic        obs_out [64];
  logic        obs_oe [64];
  logic [15:0] phy_word = '0;
  logic [15:0] model_rd = '0;
  logic        mdio_in_drv;

  // PHY: drives 1 during turnaround and data MSB-first for frame periods 16..31.
  always_comb begin
    int pb;
    pb = rise_cnt - PRE;
    mdio_in_drv = 1'b1;
    if (pb >= 16 && pb <= 31) mdio_in_drv = phy_word[31 - pb];
  end
  assign ifc.mdio_in = mdio_in_drv;

  always @(negedge clk) begin
    if (ifc.mdc && !mdc_q) begin
      if (rise_cnt < 64) begin
        obs_out[rise_cnt] = ifc.mdio_out;
        obs_oe[rise_cnt]  = ifc.mdio_oe;
      end
      rise_cnt++;
    end
    if (!ifc.busy) begin
      if (rise_cnt != 0) last_rises = rise_cnt;
      rise_cnt = 0;
    end
    if (ifc.data_rdy) rdy_cnt++;
    mdc_q = ifc.mdc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] td, input logic hold);
    @(negedge clk);
    ifc.t_data = td;
    ifc.start  = 1'b1;
    rdy_cnt    = 0;
    last_rises = 0;
    @(posedge clk);
    #1;
    if (!hold) ifc.start = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] td, input logic [15:0] exp_rd,
                           input int exp_rdy, input int mode);
    int   cyc;
    int   bad_bits;
    int   b;
    logic e_oe, e_out;
    cyc = 0;
    bad_bits = 0;
    while (ifc.busy && cyc < 4 * LAT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mode == 1 && cyc == 40) begin
        ifc.start  = 1'b1;
        ifc.t_data = ~td;
      end
      if (mode == 1 && cyc == 44) ifc.start = 1'b0;
      if (mode == 2 && cyc == (PRE + 20) * CLK_DIV + 1) begin
        rst = 1'b1;
        #1;
        check("reset_mid_outputs",
              {27'd0, ifc.mdc, ifc.mdio_out, ifc.mdio_oe, ifc.data_rdy, ifc.busy}, 32'd0);
        check("reset_mid_rd_data", {16'd0, ifc.rd_data}, 32'd0);
        model_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_no_rdy", rdy_cnt, 0);
        return;
      end
    end
    check("busy_latency", cyc, LAT);
    @(negedge clk);
    #1;
    check("mdc_periods", last_rises, NB);
    for (int k = 0; k < NB; k++) begin
      e_oe  = 1'b1;
      e_out = 1'b1;
      if (k >= PRE) begin
        b = k - PRE;
        e_out = td[31 - b];
        if (td[29:28] == 2'b10 && b >= 14) e_oe = 1'b0;
      end
      if (obs_oe[k] !== e_oe || (e_oe && obs_out[k] !== e_out)) bad_bits++;
    end
    check("frame_bits", bad_bits, 0);
    check("data_rdy_pulses", rdy_cnt, exp_rdy);
    check("rd_data", {16'd0, ifc.rd_data}, {16'd0, exp_rd});
    model_rd = exp_rd;
  endtask

  initial begin
    vec_t tbl [9];
    tbl[0] = '{32'h5FFFABCD, 16'h0000, 16'h0000, 0, 0, 32'h0, 16'h0};
    tbl[1] = '{32'h6BFF0000, 16'hDCBA, 16'hDCBA, 1, 0, 32'h0, 16'h0};
    tbl[2] = '{32'h0C215A5A, 16'h1111, 16'hDCBA, 0, 0, 32'h0, 16'h0};
    tbl[3] = '{32'h7F001111, 16'h2222, 16'hDCBA, 0, 0, 32'h0, 16'h0};
    tbl[4] = '{32'h60000000, 16'h8001, 16'h8001, 1, 0, 32'h0, 16'h0};
    tbl[5] = '{32'h5A5A5A5A, 16'h3333, 16'h8001, 0, 1, 32'h0, 16'h0};
    tbl[6] = '{32'h6BFF0000, 16'h1234, 16'h0000, 0, 2, 32'h0, 16'h0};
    tbl[7] = '{32'h6AAA0000, 16'hFFFF, 16'hFFFF, 1, 0, 32'h0, 16'h0};
    tbl[8] = '{32'h5FFFABCD, 16'h0F0F, 16'hFFFF, 0, 3, 32'h6BFF0000, 16'h0F0F};

    rst        = 1'b1;
    ifc.start  = 1'b0;
    ifc.t_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {27'd0, ifc.mdc, ifc.mdio_out, ifc.mdio_oe, ifc.data_rdy, ifc.busy}, 32'd0);
    check("reset_rd_data", {16'd0, ifc.rd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_quiet", {29'd0, ifc.mdc, ifc.mdio_oe, ifc.busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      phy_word = tbl[i].phy;
      launch(tbl[i].td, tbl[i].mode == 3);
      if (tbl[i].mode == 3) ifc.t_data = tbl[i].td2;
      run_frame(tbl[i].td, tbl[i].exp_rd, tbl[i].exp_rdy, tbl[i].mode);
      if (tbl[i].mode == 3) begin
        @(posedge clk);
        #1;
        check("b2b_restart", {31'd0, ifc.busy}, 32'd1);
        ifc.start  = 1'b0;
        rdy_cnt    = 0;
        last_rises = 0;
        run_frame(tbl[i].td2, tbl[i].exp_rd2, 1, 0);
      end
    end

    for (int i = 0; i < 20; i++) begin
      logic [31:0] td;
      logic [15:0] ph;
      logic        rd;
      td = $urandom;
      if (i % 2 == 0) td[29:28] = 2'b10;
      ph = 16'($urandom);
      rd = td[29:28] == 2'b10;
      phy_word = ph;
      launch(td, 1'b0);
      run_frame(td, rd ? ph : model_rd, rd ? 1 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
